// File: rtl/fwd_pkg.sv
// Shared encodings and width helpers for the forwarding/hazard unit.
package fwd_pkg;

    localparam int FWD_RF         = 0;
    localparam int FWD_STAGE_BASE = 1;

    function automatic int calc_aw(input int num_regs);
        return $clog2(num_regs);
    endfunction

    function automatic int calc_lw(input int max_lat);
        return $clog2(max_lat + 1);
    endfunction

    function automatic int calc_sw(input int num_fwd_stages);
        return $clog2(num_fwd_stages + 1);
    endfunction

endpackage

// File: rtl/fwd_prio_mux.sv
// Priority match of one source operand against the producer stages; youngest stage wins.
module fwd_prio_mux
    import fwd_pkg::*;
#(
    parameter int NUM_FWD_STAGES = 2,
    parameter int AW             = 5,
    parameter int SW             = 2
) (
    input  logic [AW-1:0]                rs,
    input  logic                         rs_used,
    input  logic [NUM_FWD_STAGES-1:0]    stage_wen,
    input  logic [NUM_FWD_STAGES*AW-1:0] stage_rd,
    output logic [SW-1:0]                sel
);

    always_comb begin
        sel = SW'(FWD_RF);
        // Walk oldest to youngest so the lowest matching index overwrites last.
        for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
            if (stage_wen[k] && (stage_rd[k*AW +: AW] == rs)) begin
                sel = SW'(k + FWD_STAGE_BASE);
            end
        end
        if (!rs_used || (rs == '0)) begin
            sel = SW'(FWD_RF);
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Countdown scoreboard for multi-cycle results, RAW/WAW stall generation and
// per-port forwarding select for the instruction in ID.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int NUM_REGS       = 32,
    parameter int NUM_RD_PORTS   = 2,
    parameter int NUM_FWD_STAGES = 2,
    parameter int MAX_LAT        = 4,
    parameter int AW             = calc_aw(NUM_REGS),
    parameter int LW             = calc_lw(MAX_LAT),
    parameter int SW             = calc_sw(NUM_FWD_STAGES)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         issue_valid,
    input  logic                         issue_wen,
    input  logic [AW-1:0]                issue_rd,
    input  logic [LW-1:0]                issue_lat,
    input  logic [NUM_RD_PORTS*AW-1:0]   id_rs,
    input  logic [NUM_RD_PORTS-1:0]      id_rs_used,
    input  logic [AW-1:0]                id_rd,
    input  logic                         id_wen,
    input  logic [LW-1:0]                id_lat,
    input  logic [NUM_FWD_STAGES-1:0]    stage_wen,
    input  logic [NUM_FWD_STAGES*AW-1:0] stage_rd,
    output logic [NUM_RD_PORTS*SW-1:0]   fwd_sel,
    output logic                         stall,
    output logic                         sb_busy
);

    logic [LW-1:0] cnt_q   [1:NUM_REGS-1];
    logic [LW-1:0] cnt_all [NUM_REGS];
    logic          issue_hit;
    logic [NUM_RD_PORTS*SW-1:0] fwd_sel_raw;
    logic          raw_stall;
    logic          waw_stall;
    logic          busy_raw;

    assign issue_hit = issue_valid && issue_wen && (issue_rd != '0) && (issue_lat != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 1; r < NUM_REGS; r++) cnt_q[r] <= '0;
        end else if (flush) begin
            for (int r = 1; r < NUM_REGS; r++) cnt_q[r] <= '0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (issue_hit && (issue_rd == AW'(r))) begin
                    cnt_q[r] <= issue_lat;
                end else if (cnt_q[r] != '0) begin
                    cnt_q[r] <= cnt_q[r] - 1'b1;
                end
            end
        end
    end

    // Register 0 reads as a permanently idle entry.
    always_comb begin
        cnt_all[0] = '0;
        for (int r = 1; r < NUM_REGS; r++) cnt_all[r] = cnt_q[r];
    end

    always_comb begin
        busy_raw = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (cnt_q[r] != '0) busy_raw = 1'b1;
        end
    end

    always_comb begin
        raw_stall = 1'b0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            if (id_rs_used[p] && (id_rs[p*AW +: AW] != '0) &&
                (cnt_all[id_rs[p*AW +: AW]] != '0)) begin
                raw_stall = 1'b1;
            end
        end
    end

    // An older write still in flight longer than the ID instruction would land last.
    assign waw_stall = id_wen && (id_rd != '0) && (cnt_all[id_rd] > id_lat);

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
        fwd_prio_mux #(
            .NUM_FWD_STAGES (NUM_FWD_STAGES),
            .AW             (AW),
            .SW             (SW)
        ) u_mux (
            .rs        (id_rs[p*AW +: AW]),
            .rs_used   (id_rs_used[p]),
            .stage_wen (stage_wen),
            .stage_rd  (stage_rd),
            .sel       (fwd_sel_raw[p*SW +: SW])
        );
    end

    assign fwd_sel = rst_n ? fwd_sel_raw : '0;
    assign stall   = rst_n && (raw_stall || waw_stall);
    assign sb_busy = rst_n && busy_raw;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Randomized and directed checks of fwd_scoreboard against a behavioural model.
module tb_fwd_scoreboard;

    localparam int NR = 32;
    localparam int NP = 2;
    localparam int NS = 2;
    localparam int AW = 5;
    localparam int LW = 3;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          issue_valid;
    logic          issue_wen;
    logic [AW-1:0] issue_rd;
    logic [LW-1:0] issue_lat;
    logic [NP*AW-1:0] id_rs;
    logic [NP-1:0] id_rs_used;
    logic [AW-1:0] id_rd;
    logic          id_wen;
    logic [LW-1:0] id_lat;
    logic [NS-1:0] stage_wen;
    logic [NS*AW-1:0] stage_rd;
    logic [NP*SW-1:0] fwd_sel;
    logic          stall;
    logic          sb_busy;

    int checks = 0;
    int errors = 0;
    int m_cnt [NR];

    always #5 clk = ~clk;

    fwd_scoreboard dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .issue_valid(issue_valid), .issue_wen(issue_wen),
        .issue_rd(issue_rd), .issue_lat(issue_lat),
        .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_rd(id_rd), .id_wen(id_wen), .id_lat(id_lat),
        .stage_wen(stage_wen), .stage_rd(stage_rd),
        .fwd_sel(fwd_sel), .stall(stall), .sb_busy(sb_busy)
    );

    // Behavioural reference: pending-cycle count per register, evaluated per rule.
    function automatic logic m_stall();
        for (int p = 0; p < NP; p++) begin
            int rs = int'(id_rs[p*AW +: AW]);
            if (id_rs_used[p] && rs != 0 && m_cnt[rs] > 0) return 1'b1;
        end
        if (id_wen && id_rd != 0 && m_cnt[id_rd] > int'(id_lat)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [NP*SW-1:0] m_sel();
        logic [NP*SW-1:0] v = '0;
        for (int p = 0; p < NP; p++) begin
            int rs = int'(id_rs[p*AW +: AW]);
            int s = 0;
            if (id_rs_used[p] && rs != 0) begin
                for (int k = NS - 1; k >= 0; k--)
                    if (stage_wen[k] && int'(stage_rd[k*AW +: AW]) == rs) s = k + 1;
            end
            v[p*SW +: SW] = SW'(s);
        end
        return v;
    endfunction

    function automatic logic m_busy();
        for (int r = 1; r < NR; r++) if (m_cnt[r] > 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void m_clear();
        for (int r = 0; r < NR; r++) m_cnt[r] = 0;
    endfunction

    task automatic step();
        if (flush) m_clear();
        else begin
            for (int r = 1; r < NR; r++) begin
                if (issue_valid && issue_wen && int'(issue_rd) == r && issue_lat != 0)
                    m_cnt[r] = int'(issue_lat);
                else if (m_cnt[r] > 0)
                    m_cnt[r] = m_cnt[r] - 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; issue_valid = 0; issue_wen = 0; issue_rd = 0; issue_lat = 0;
        id_rs = 0; id_rs_used = 0; id_rd = 0; id_wen = 0; id_lat = 0;
        stage_wen = 0; stage_rd = 0;
    endtask

    task automatic issue(input int rd, input int lat);
        issue_valid = 1; issue_wen = 1; issue_rd = AW'(rd); issue_lat = LW'(lat);
    endtask

    task automatic use_rs(input int rs0, input int rs1);
        id_rs = {AW'(rs1), AW'(rs0)}; id_rs_used = 2'b11;
    endtask

    task automatic test_reset();
        rst_n = 0; idle(); m_clear();
        use_rs(9, 9); stage_wen = 2'b01; stage_rd = {AW'(0), AW'(9)};
        #1;
        checks++;
        if (fwd_sel !== '0 || stall !== 1'b0 || sb_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: fwd_sel=%0h stall=%0b busy=%0b, required all 0", fwd_sel, stall, sb_busy);
        end
        @(negedge clk); rst_n = 1; idle();
        @(posedge clk); #1;
        issue(5, 3); step(); idle(); step();
        use_rs(5, 0);
        rst_n = 0; #1; m_clear();
        checks++;
        if (sb_busy !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_count: busy=%0b stall=%0b, required 0 0", sb_busy, stall);
        end
        @(posedge clk); #1; rst_n = 1; #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_stall: stall=%0b, required 0", stall);
        end
    endtask

    task automatic test_load_use();
        int n = 0;
        idle(); issue(7, 1); step(); idle();
        use_rs(7, 0);
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (stall !== m_stall()) begin
                errors++;
                $display("FAIL load_use_cycle%0d: stall=%0b, required %0b", i, stall, m_stall());
            end
            if (stall === 1'b1) n++;
            step();
        end
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL load_use_len: stall cycles=%0d, required 1", n);
        end
        stage_wen = 2'b01; stage_rd = {AW'(0), AW'(7)}; #1;
        checks++;
        if (fwd_sel[SW-1:0] !== 2'd1) begin
            errors++;
            $display("FAIL load_use_fwd: fwd_sel[0]=%0d, required 1", fwd_sel[SW-1:0]);
        end
    endtask

    task automatic test_priority();
        idle(); use_rs(9, 0); stage_wen = 2'b11; stage_rd = {AW'(9), AW'(9)}; #1;
        checks++;
        if (fwd_sel !== 4'b0001) begin
            errors++;
            $display("FAIL priority_fwd: fwd_sel=%0h, required 1", fwd_sel);
        end
        use_rs(0, 0); stage_wen = 2'b10; stage_rd = {AW'(0), AW'(3)}; #1;
        checks++;
        if (fwd_sel !== 4'b0000) begin
            errors++;
            $display("FAIL zero_reg_fwd: fwd_sel=%0h, required 0", fwd_sel);
        end
        use_rs(6, 6); id_rs_used = 2'b01; stage_wen = 2'b10; stage_rd = {AW'(6), AW'(1)}; #1;
        checks++;
        if (fwd_sel !== 4'b0010) begin
            errors++;
            $display("FAIL stage1_fwd_unused_port: fwd_sel=%0h, required 2", fwd_sel);
        end
    endtask

    task automatic test_collision();
        int n = 0;
        idle(); issue(3, 1); step(); issue(3, 4); step(); idle();
        use_rs(3, 0);
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (stall !== m_stall()) begin
                errors++;
                $display("FAIL collision_cycle%0d: stall=%0b, required %0b", i, stall, m_stall());
            end
            if (stall === 1'b1) n++;
            step();
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL collision_len: stall cycles=%0d, required 4", n);
        end
    endtask

    task automatic test_waw();
        int n = 0;
        idle(); issue(4, 4); step(); idle();
        id_wen = 1; id_rd = 4; id_lat = 0;
        for (int i = 0; i < 7; i++) begin
            #1;
            if (stall === 1'b1) n++;
            step();
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL waw_len: stall cycles=%0d, required 4", n);
        end
        idle(); issue(4, 4); step(); idle(); step();
        id_wen = 1; id_rd = 4; id_lat = 3; #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL waw_lat3: stall=%0b with cnt=3, required 0", stall);
        end
        id_lat = 2; #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL waw_lat2: stall=%0b with cnt=3, required 1", stall);
        end
        idle(); for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_flush();
        idle(); issue(2, 4); step(); issue(6, 2); step();
        issue(8, 2); flush = 1; step(); idle();
        checks++;
        if (sb_busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_busy: busy=%0b, required 0", sb_busy);
        end
        for (int r = 0; r < 3; r++) begin
            int regs [3] = '{2, 6, 8};
            use_rs(regs[r], 0); #1;
            checks++;
            if (stall !== 1'b0) begin
                errors++;
                $display("FAIL flush_stall_r%0d: stall=%0b, required 0", regs[r], stall);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            idle();
            id_rs = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            id_rs_used = NP'($urandom);
            id_wen = 1'($urandom); id_rd = AW'($urandom_range(0, 7)); id_lat = LW'($urandom_range(0, 4));
            stage_wen = NS'($urandom);
            stage_rd = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            flush = ($urandom_range(0, 19) == 0);
            #1;
            checks++;
            if (stall !== m_stall() || fwd_sel !== m_sel() || sb_busy !== m_busy()) begin
                errors++;
                $display("FAIL random_%0d: stall=%0b fwd=%0h busy=%0b, required %0b %0h %0b",
                         i, stall, fwd_sel, sb_busy, m_stall(), m_sel(), m_busy());
            end
            if ($urandom_range(0, 1) == 1 && !m_stall())
                issue($urandom_range(0, 7), $urandom_range(0, 4));
            step();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_priority();
        test_collision();
        test_waw();
        test_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
